// File: rtl/recip_result_stage_pkg.sv
// recip_result_stage_pkg: shared latency helper and sizing constants for the reciprocal pipeline
package recip_result_stage_pkg;
  localparam int ITERATIONS = 2;
  function automatic int recip_latency(input int iterations);
    return 7 + 3 * iterations + 0;
  endfunction
  localparam int CORE_LATENCY = recip_latency(ITERATIONS);
endpackage

// File: rtl/recip_result_stage_fifo.sv
// result_fifo: small result buffer with synchronous write/read and occupancy output
module result_fifo import recip_result_stage_pkg::*; #(
  parameter int W     = 25,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       i_wr,
  input  logic [W-1:0]               i_wdata,
  input  logic                       i_rd,
  output logic [W-1:0]               o_rdata,
  output logic                       o_valid,
  output logic [$clog2(DEPTH+1)-1:0] o_occ
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_occ;
  logic          w_rd;
  assign w_rd    = i_rd && o_valid;
  assign o_valid = r_occ != '0;
  assign o_rdata = r_mem[r_rp];
  assign o_occ   = r_occ;
  // storage, wrapping pointers and occupancy; read and write may coincide at any fill level
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_occ <= '0;
    end else begin
      if (i_wr) begin
        r_mem[r_wp] <= i_wdata;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_rd) r_rp <= r_rp + 1'b1;
      r_occ <= r_occ + CW'(i_wr) - CW'(w_rd);
    end
  end
endmodule

// File: rtl/recip_result_stage.sv
// recip_result_stage: issues operands to the fixed-latency core, formats results, buffers them with credit flow control
module recip_result_stage import recip_result_stage_pkg::*; #(
  parameter int NUMBER_WIDTH = 24,
  parameter int LATENCY      = CORE_LATENCY,
  parameter int SHIFT        = 0,
  parameter int OUT_WIDTH    = 24,
  parameter int DEPTH        = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [NUMBER_WIDTH-1:0]   s_data,
  output logic [NUMBER_WIDTH-1:0]   core_in,
  input  logic [2*NUMBER_WIDTH-1:0] core_out,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [OUT_WIDTH-1:0]      m_data,
  output logic                      m_div0
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int RW = 2*NUMBER_WIDTH + 1;
  localparam int RB = SHIFT > 0 ? SHIFT - 1 : 0;
  logic [LATENCY-1:0]      r_tag_v, r_tag_z;
  logic [CW-1:0]           r_inflight;
  logic [CW-1:0]           w_occ;
  logic                    w_issue, w_arrive, w_zero, w_rnd, w_sat;
  logic [2*NUMBER_WIDTH-1:0] w_t;
  logic [RW-1:0]           w_r;
  logic [OUT_WIDTH:0]      w_wdata, w_rdata;
  assign core_in  = s_data;
  assign w_issue  = s_valid && s_ready;
  assign w_arrive = r_tag_v[LATENCY-1];
  assign w_zero   = r_tag_z[LATENCY-1];
  assign s_ready  = ({1'b0, w_occ} + {1'b0, r_inflight}) < (CW+1)'(DEPTH);
  // round half up after the shift, saturate on overflow or a zero operand
  always_comb begin
    w_t     = core_out >> SHIFT;
    w_rnd   = SHIFT > 0 ? core_out[RB] : 1'b0;
    w_r     = {1'b0, w_t} + RW'(w_rnd);
    w_sat   = |(w_r >> OUT_WIDTH);
    w_wdata = {w_zero, (w_sat || w_zero) ? {OUT_WIDTH{1'b1}} : OUT_WIDTH'(w_r)};
  end
  // tag line mirrors the core pipeline; inflight counts operands not yet written back
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tag_v    <= '0;
      r_tag_z    <= '0;
      r_inflight <= '0;
    end else begin
      r_tag_v    <= (r_tag_v << 1) | LATENCY'(w_issue);
      r_tag_z    <= (r_tag_z << 1) | LATENCY'(w_issue && s_data == '0);
      r_inflight <= r_inflight + CW'(w_issue) - CW'(w_arrive);
    end
  end
  result_fifo #(.W(OUT_WIDTH+1), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_wr    (w_arrive),
    .i_wdata (w_wdata),
    .i_rd    (m_ready),
    .o_rdata (w_rdata),
    .o_valid (m_valid),
    .o_occ   (w_occ)
  );
  assign m_data = w_rdata[OUT_WIDTH-1:0];
  assign m_div0 = w_rdata[OUT_WIDTH];
endmodule
